// File: rtl/z_mips_pkg.sv
// Shared MIPS encodings, FSM states and decode helper for the z_ALU issue stage.
// Purely declarative. It has no latency and no flow control.
package z_mips_pkg;
   localparam int XLEN  = 32;
   localparam int REG_W = 5;
   localparam int OPC_W = 6;
   localparam int IMM_W = 16;
   localparam int NREGS = 32;

   localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OPC_W-1:0] OP_ADDIU = 6'b001001;
   localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;

   localparam logic [OPC_W-1:0] FN_ADDU = 6'b100001;
   localparam logic [OPC_W-1:0] FN_SUBU = 6'b100011;
   localparam logic [OPC_W-1:0] FN_NOR  = 6'b100111;
   localparam logic [OPC_W-1:0] FN_SLL  = 6'b000000;
   localparam logic [OPC_W-1:0] FN_SRL  = 6'b000010;

   typedef enum logic [2:0] {IDLE, EXEC, WB, BR, MEM} state_t;

   // Operand-routing class of an instruction; K_ILLEGAL marks unsupported encodings.
   typedef enum logic [2:0] {
      K_ILLEGAL, K_ALU_R, K_ALU_SEXT, K_ALU_ZEXT, K_BRANCH, K_LOAD, K_STORE
   } kind_t;

   function automatic kind_t decode(input logic [OPC_W-1:0] op, input logic [OPC_W-1:0] fn);
      kind_t k;
      k = K_ILLEGAL;
      case (op)
         OP_RTYPE: if (fn == FN_ADDU || fn == FN_SUBU || fn == FN_NOR ||
                       fn == FN_SLL  || fn == FN_SRL) k = K_ALU_R;
         OP_ADDIU: k = K_ALU_SEXT;
         OP_ANDI:  k = K_ALU_ZEXT;
         OP_BEQ,
         OP_BNE:   k = K_BRANCH;
         OP_LW:    k = K_LOAD;
         OP_SW:    k = K_STORE;
         default:  k = K_ILLEGAL;
      endcase
      return k;
   endfunction
endpackage

// File: rtl/z_regfile.sv
// 32x32 register file. It has two combinational read ports and one write port. R0 always reads 0.
// A write is visible to reads in the cycle after its edge. It has no backpressure.
// An optional debug read port exists when Z_ALU_ISSUE_DBG_EN is defined.
module z_regfile
   import z_mips_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             we,
   input  logic [REG_W-1:0] waddr,
   input  logic [XLEN-1:0]  wdata,
   input  logic [REG_W-1:0] raddr_a,
   output logic [XLEN-1:0]  rdata_a,
   input  logic [REG_W-1:0] raddr_b,
   output logic [XLEN-1:0]  rdata_b
`ifdef Z_ALU_ISSUE_DBG_EN
   ,
   input  logic [REG_W-1:0] dbg_addr,
   output logic [XLEN-1:0]  dbg_data
`endif
);
   logic [XLEN-1:0] regs [NREGS];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we && waddr != '0) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];
`ifdef Z_ALU_ISSUE_DBG_EN
   assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
`endif
endmodule

// File: rtl/z_alu_issue.sv
// Single-issue stage. It decodes one instruction, drives the z_ALU and then performs writeback, branch or lw/sw.
// Latency: the ALU or branch result pulses 2 cycles after accept. Memory operations take 1 more cycle plus the ack wait.
// Backpressure: ins_ready_out is high only in IDLE. Z_ALU_ISSUE_DBG_EN adds a debug register read.
module z_alu_issue
   import z_mips_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        ins_valid_in,
   input  logic [31:0] ins_in,
   input  logic [31:0] pc_in,
   output logic        ins_ready_out,
   input  logic        rf_we_in,
   input  logic [4:0]  rf_waddr_in,
   input  logic [31:0] rf_wdata_in,
   output logic [31:0] alu_a_out,
   output logic [31:0] alu_b_out,
   output logic [4:0]  alu_shamt_out,
   output logic [31:0] alu_ins_out,
   input  logic [31:0] alu_out_in,
   input  logic        alu_zero_in,
   output logic        result_valid_out,
   output logic [4:0]  result_rd_out,
   output logic [31:0] result_data_out,
   output logic        branch_valid_out,
   output logic        branch_taken_out,
   output logic [31:0] branch_target_out,
   output logic        mem_req_out,
   output logic        mem_we_out,
   output logic [31:0] mem_addr_out,
   output logic [31:0] mem_wdata_out,
   input  logic        mem_ack_in,
   input  logic [31:0] mem_rdata_in,
   output logic        mem_err_out,
   output logic        illegal_out
`ifdef Z_ALU_ISSUE_DBG_EN
   ,
   input  logic [4:0]  dbg_addr_in,
   output logic [31:0] dbg_data_out
`endif
);
   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      state_q, state_d;
   kind_t       kind_q, kind_in;
   logic [31:0] ins_q, pc_q, res_q, wb_data_q;
   logic [4:0]  wb_rd_q;
   logic        zero_q, illegal_q, mem_err_q;
   logic [7:0]  mem_cnt_q;

   logic        accept, start, in_exec, in_mem, mem_timeout;
   logic [31:0] rs_val, rt_val, imm_sext, imm_zext;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   assign kind_in     = decode(ins_in[31:26], ins_in[5:0]);
   assign accept      = ins_valid_in && (state_q == IDLE);
   assign start       = accept && (kind_in != K_ILLEGAL);
   assign in_exec     = (state_q == EXEC);
   assign in_mem      = (state_q == MEM);
   assign mem_timeout = in_mem && !mem_ack_in && (mem_cnt_q == TO_LAST);

   // Preloads only land in IDLE and writebacks only in WB, so the two write sources never collide.
   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = rf_waddr_in;
      rf_wdata = rf_wdata_in;
      if (state_q == IDLE && rf_we_in) begin
         rf_we = 1'b1;
      end else if (state_q == WB) begin
         rf_we    = 1'b1;
         rf_waddr = wb_rd_q;
         rf_wdata = wb_data_q;
      end
   end

   z_regfile u_regfile (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata),
      .raddr_a (ins_q[25:21]),
      .rdata_a (rs_val),
      .raddr_b (ins_q[20:16]),
      .rdata_b (rt_val)
`ifdef Z_ALU_ISSUE_DBG_EN
      ,
      .dbg_addr (dbg_addr_in),
      .dbg_data (dbg_data_out)
`endif
   );

   assign imm_sext = {{16{ins_q[15]}}, ins_q[15:0]};
   assign imm_zext = {16'h0000, ins_q[15:0]};

   // Operands come from latched ins_q and the register file, so they stay stable for the whole EXEC cycle.
   always_comb begin
      alu_a_out     = '0;
      alu_b_out     = '0;
      alu_shamt_out = '0;
      alu_ins_out   = '0;
      if (in_exec) begin
         alu_a_out   = rs_val;
         alu_ins_out = ins_q;
         case (kind_q)
            K_ALU_R: begin
               alu_b_out     = rt_val;
               alu_shamt_out = ins_q[10:6];
            end
            K_BRANCH:                   alu_b_out = rt_val;
            K_ALU_ZEXT:                 alu_b_out = imm_zext;
            K_ALU_SEXT, K_LOAD, K_STORE: alu_b_out = imm_sext;
            default:                    alu_b_out = '0;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = EXEC;
         EXEC: begin
            case (kind_q)
               K_BRANCH:        state_d = BR;
               K_LOAD, K_STORE: state_d = MEM;
               default:         state_d = WB;
            endcase
         end
         WB:  state_d = IDLE;
         BR:  state_d = IDLE;
         MEM: begin
            if (mem_ack_in)       state_d = (kind_q == K_LOAD) ? WB : IDLE;
            else if (mem_timeout) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q   <= IDLE;
         kind_q    <= K_ILLEGAL;
         ins_q     <= '0;
         pc_q      <= '0;
         res_q     <= '0;
         wb_data_q <= '0;
         wb_rd_q   <= '0;
         zero_q    <= 1'b0;
         illegal_q <= 1'b0;
         mem_err_q <= 1'b0;
         mem_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= accept && (kind_in == K_ILLEGAL);
         mem_err_q <= mem_timeout;
         if (start) begin
            ins_q  <= ins_in;
            pc_q   <= pc_in;
            kind_q <= kind_in;
         end
         if (in_exec) begin
            res_q     <= alu_out_in;
            zero_q    <= alu_zero_in;
            wb_data_q <= alu_out_in;
            wb_rd_q   <= (kind_q == K_ALU_R) ? ins_q[15:11] : ins_q[20:16];
            mem_cnt_q <= '0;
         end
         if (in_mem) begin
            mem_cnt_q <= mem_cnt_q + 8'd1;
            if (mem_ack_in) wb_data_q <= mem_rdata_in;
         end
      end
   end

   assign ins_ready_out     = (state_q == IDLE);
   assign illegal_out       = illegal_q;
   assign mem_err_out       = mem_err_q;

   assign result_valid_out  = (state_q == WB);
   assign result_rd_out     = (state_q == WB) ? wb_rd_q : '0;
   assign result_data_out   = (state_q == WB) ? wb_data_q : '0;

   // Opcode bit 0 separates bne from beq.
   assign branch_valid_out  = (state_q == BR);
   assign branch_taken_out  = (state_q == BR) && (ins_q[26] ? !zero_q : zero_q);
   assign branch_target_out = (state_q == BR) ?
                              (pc_q + 32'd4 + {imm_sext[29:0], 2'b00}) : '0;

   assign mem_req_out       = in_mem;
   assign mem_we_out        = in_mem && (kind_q == K_STORE);
   assign mem_addr_out      = in_mem ? res_q : '0;
   assign mem_wdata_out     = (in_mem && kind_q == K_STORE) ? rt_val : '0;
endmodule

// File: tb/tb_z_alu_issue.sv
// Directed table-driven bench for z_alu_issue with a behavioural ALU and hand-sequenced memory corner cases.
module tb_z_alu_issue;
   localparam logic [5:0] T_ADDU = 6'b100001, T_SUBU = 6'b100011, T_NOR = 6'b100111;
   localparam logic [5:0] T_SLL = 6'b000000, T_SRL = 6'b000010;
   localparam logic [5:0] T_ADDIU = 6'b001001, T_ANDI = 6'b001100, T_BEQ = 6'b000100;
   localparam logic [5:0] T_BNE = 6'b000101, T_LW = 6'b100011, T_SW = 6'b101011;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        ins_valid_in = 1'b0;
   logic [31:0] ins_in = '0, pc_in = '0;
   logic        ins_ready_out;
   logic        rf_we_in = 1'b0;
   logic [4:0]  rf_waddr_in = '0;
   logic [31:0] rf_wdata_in = '0;
   logic [31:0] alu_a_out, alu_b_out, alu_ins_out, alu_out_in;
   logic [4:0]  alu_shamt_out, result_rd_out;
   logic        alu_zero_in, result_valid_out, branch_valid_out, branch_taken_out;
   logic [31:0] result_data_out, branch_target_out, mem_addr_out, mem_wdata_out;
   logic        mem_req_out, mem_we_out, mem_err_out, illegal_out;
   logic        mem_ack_in = 1'b0;
   logic [31:0] mem_rdata_in = '0;

   int n_chk = 0;
   int n_fail = 0;

   z_alu_issue #(.MEM_TIMEOUT(16)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .ins_valid_in(ins_valid_in), .ins_in(ins_in),
      .pc_in(pc_in), .ins_ready_out(ins_ready_out), .rf_we_in(rf_we_in),
      .rf_waddr_in(rf_waddr_in), .rf_wdata_in(rf_wdata_in), .alu_a_out(alu_a_out),
      .alu_b_out(alu_b_out), .alu_shamt_out(alu_shamt_out), .alu_ins_out(alu_ins_out),
      .alu_out_in(alu_out_in), .alu_zero_in(alu_zero_in),
      .result_valid_out(result_valid_out), .result_rd_out(result_rd_out),
      .result_data_out(result_data_out), .branch_valid_out(branch_valid_out),
      .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out),
      .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
      .mem_wdata_out(mem_wdata_out), .mem_ack_in(mem_ack_in), .mem_rdata_in(mem_rdata_in),
      .mem_err_out(mem_err_out), .illegal_out(illegal_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] alu_model(input logic [31:0] ins, input logic [31:0] a,
                                             input logic [31:0] b, input logic [4:0] sh);
      logic [5:0] op, fn;
      op = ins[31:26];
      fn = ins[5:0];
      if (op == 6'b000000) begin
         case (fn)
            T_ADDU:  return a + b;
            T_SUBU:  return a - b;
            T_NOR:   return ~(a | b);
            T_SRL:   return b >> sh;
            default: return b << sh;
         endcase
      end
      if (op == T_ANDI) return a & b;
      if (op == T_BEQ || op == T_BNE) return a - b;
      return a + b;
   endfunction

   always_comb begin
      alu_out_in  = alu_model(alu_ins_out, alu_a_out, alu_b_out, alu_shamt_out);
      alu_zero_in = (alu_out_in == 32'h0);
   end

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
      chk("ready_before_issue", 32'(ins_ready_out), 1);
      ins_valid_in = 1'b1;
      ins_in       = ins;
      pc_in        = pc;
      tick();
      ins_valid_in = 1'b0;
   endtask

   task automatic preload(input logic [4:0] r, input logic [31:0] d);
      rf_we_in = 1'b1; rf_waddr_in = r; rf_wdata_in = d;
      tick();
      rf_we_in = 1'b0;
   endtask

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic        is_br;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        taken;
      logic [31:0] target;
   } vec_t;

   vec_t vt [14];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      vt[0]  = '{rtype(1, 2, 3, 0, T_ADDU), 0, 32'h0FB7AFF0, 32'hA00D0FF0, 0, 0, 3, 32'hAFC4BFE0, 0, 0};
      vt[1]  = '{rtype(0, 2, 4, 2, T_SLL), 0, 32'h0, 32'hA00D0FF0, 2, 0, 4, 32'h80343FC0, 0, 0};
      vt[2]  = '{itype(T_ANDI, 1, 5, 16'hFFFF), 0, 32'h0FB7AFF0, 32'h0000FFFF, 0, 0, 5, 32'h0000AFF0, 0, 0};
      vt[3]  = '{itype(T_ADDIU, 0, 6, 16'hFFFF), 0, 32'h0, 32'hFFFFFFFF, 0, 0, 6, 32'hFFFFFFFF, 0, 0};
      vt[4]  = '{rtype(3, 1, 8, 0, T_SUBU), 0, 32'hAFC4BFE0, 32'h0FB7AFF0, 0, 0, 8, 32'hA00D0FF0, 0, 0};
      vt[5]  = '{rtype(1, 2, 9, 0, T_NOR), 0, 32'h0FB7AFF0, 32'hA00D0FF0, 0, 0, 9, 32'h5040500F, 0, 0};
      vt[6]  = '{rtype(0, 2, 10, 4, T_SRL), 0, 32'h0, 32'hA00D0FF0, 4, 0, 10, 32'h0A00D0FF, 0, 0};
      vt[7]  = '{itype(T_BEQ, 1, 1, 16'h0004), 32'h100, 32'h0FB7AFF0, 32'h0FB7AFF0, 0, 1, 0, 0, 1, 32'h114};
      vt[8]  = '{itype(T_BNE, 1, 1, 16'h0004), 32'h100, 32'h0FB7AFF0, 32'h0FB7AFF0, 0, 1, 0, 0, 0, 32'h114};
      vt[9]  = '{itype(T_BEQ, 1, 2, 16'hFFFE), 32'h200, 32'h0FB7AFF0, 32'hA00D0FF0, 0, 1, 0, 0, 0, 32'h1FC};
      vt[10] = '{itype(T_BNE, 1, 2, 16'hFFFE), 32'h200, 32'h0FB7AFF0, 32'hA00D0FF0, 0, 1, 0, 0, 1, 32'h1FC};
      vt[11] = '{rtype(1, 2, 0, 0, T_ADDU), 0, 32'h0FB7AFF0, 32'hA00D0FF0, 0, 0, 0, 32'hAFC4BFE0, 0, 0};
      vt[12] = '{rtype(0, 1, 11, 0, T_ADDU), 0, 32'h0, 32'h0FB7AFF0, 0, 0, 11, 32'h0FB7AFF0, 0, 0};
      vt[13] = '{itype(T_ADDIU, 1, 12, 16'h8000), 0, 32'h0FB7AFF0, 32'hFFFF8000, 0, 0, 12, 32'h0FB72FF0, 0, 0};

      tick(); tick();
      rst_in = 1'b0;
      chk("rst_ready", 32'(ins_ready_out), 1);
      chk("rst_alu_a", alu_a_out, 0);
      chk("rst_alu_ins", alu_ins_out, 0);
      chk("rst_result_valid", 32'(result_valid_out), 0);
      chk("rst_branch_valid", 32'(branch_valid_out), 0);
      chk("rst_mem_req", 32'(mem_req_out), 0);
      chk("rst_mem_err", 32'(mem_err_out), 0);
      chk("rst_illegal", 32'(illegal_out), 0);

      preload(1, 32'h0FB7AFF0);
      preload(2, 32'hA00D0FF0);

      for (int i = 0; i < 14; i++) begin
         issue(vt[i].ins, vt[i].pc);
         chk($sformatf("v%0d_alu_a", i), alu_a_out, vt[i].a);
         chk($sformatf("v%0d_alu_b", i), alu_b_out, vt[i].b);
         chk($sformatf("v%0d_shamt", i), 32'(alu_shamt_out), 32'(vt[i].sh));
         chk($sformatf("v%0d_alu_ins", i), alu_ins_out, vt[i].ins);
         chk($sformatf("v%0d_exec_ready", i), 32'(ins_ready_out), 0);
         tick();
         if (vt[i].is_br) begin
            chk($sformatf("v%0d_br_valid", i), 32'(branch_valid_out), 1);
            chk($sformatf("v%0d_br_taken", i), 32'(branch_taken_out), 32'(vt[i].taken));
            chk($sformatf("v%0d_br_target", i), branch_target_out, vt[i].target);
            chk($sformatf("v%0d_br_no_result", i), 32'(result_valid_out), 0);
         end else begin
            chk($sformatf("v%0d_res_valid", i), 32'(result_valid_out), 1);
            chk($sformatf("v%0d_res_rd", i), 32'(result_rd_out), 32'(vt[i].rd));
            chk($sformatf("v%0d_res_data", i), result_data_out, vt[i].data);
            chk($sformatf("v%0d_no_branch", i), 32'(branch_valid_out), 0);
         end
         tick();
         chk($sformatf("v%0d_ready_after", i), 32'(ins_ready_out), 1);
         chk($sformatf("v%0d_alu_idle_zero", i), alu_a_out, 0);
      end

      // lw r7,0(r1), ack in the third MEM cycle
      issue(itype(T_LW, 1, 7, 16'h0000), 0);
      chk("lw_alu_b", alu_b_out, 0);
      tick();
      chk("lw_req1", 32'(mem_req_out), 1);
      chk("lw_we", 32'(mem_we_out), 0);
      chk("lw_addr", mem_addr_out, 32'h0FB7AFF0);
      tick();
      chk("lw_req2", 32'(mem_req_out), 1);
      tick();
      chk("lw_req3", 32'(mem_req_out), 1);
      mem_ack_in = 1'b1; mem_rdata_in = 32'hDEADBEEF;
      tick();
      mem_ack_in = 1'b0; mem_rdata_in = '0;
      chk("lw_req_dropped", 32'(mem_req_out), 0);
      chk("lw_res_valid", 32'(result_valid_out), 1);
      chk("lw_res_rd", 32'(result_rd_out), 7);
      chk("lw_res_data", result_data_out, 32'hDEADBEEF);
      tick();
      issue(rtype(7, 0, 13, 0, T_ADDU), 0);
      chk("lw_r7_readback", alu_a_out, 32'hDEADBEEF);
      tick(); tick();

      // sw r2,8(r1)
      issue(itype(T_SW, 1, 2, 16'h0008), 0);
      chk("sw_alu_b", alu_b_out, 32'h8);
      tick();
      chk("sw_req", 32'(mem_req_out), 1);
      chk("sw_we", 32'(mem_we_out), 1);
      chk("sw_addr", mem_addr_out, 32'h0FB7AFF8);
      chk("sw_wdata", mem_wdata_out, 32'hA00D0FF0);
      mem_ack_in = 1'b1;
      tick();
      mem_ack_in = 1'b0;
      chk("sw_ready", 32'(ins_ready_out), 1);
      chk("sw_no_result", 32'(result_valid_out), 0);
      chk("sw_req_dropped", 32'(mem_req_out), 0);

      // lw with no ack: timeout after 16 MEM cycles
      issue(itype(T_LW, 2, 7, 16'h0000), 0);
      tick();
      n = 0;
      while (mem_req_out && n < 40) begin
         n++;
         tick();
      end
      chk("to_req_cycles", n, 16);
      chk("to_mem_err", 32'(mem_err_out), 1);
      chk("to_ready", 32'(ins_ready_out), 1);
      chk("to_no_result", 32'(result_valid_out), 0);
      tick();
      chk("to_mem_err_pulse", 32'(mem_err_out), 0);
      issue(rtype(7, 0, 13, 0, T_ADDU), 0);
      chk("to_r7_unchanged", alu_a_out, 32'hDEADBEEF);
      tick(); tick();

      // illegal opcode
      issue({6'b111111, 26'h0}, 0);
      chk("ill_pulse", 32'(illegal_out), 1);
      chk("ill_ready", 32'(ins_ready_out), 1);
      tick();
      chk("ill_pulse_end", 32'(illegal_out), 0);

      // preload in the accept cycle reaches the operand read; preload outside IDLE is ignored
      rf_we_in = 1'b1; rf_waddr_in = 15; rf_wdata_in = 32'h12345678;
      issue(rtype(15, 0, 16, 0, T_ADDU), 0);
      rf_we_in = 1'b1; rf_waddr_in = 1; rf_wdata_in = 32'h00000BAD;
      chk("pre_same_cycle", alu_a_out, 32'h12345678);
      tick();
      rf_we_in = 1'b0;
      tick();
      issue(rtype(1, 0, 17, 0, T_ADDU), 0);
      chk("pre_outside_idle_ignored", alu_a_out, 32'h0FB7AFF0);
      tick(); tick();

      // reset while waiting in MEM
      issue(itype(T_LW, 1, 7, 16'h0000), 0);
      tick(); tick();
      chk("rstmem_req_before", 32'(mem_req_out), 1);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      chk("rstmem_req_dropped", 32'(mem_req_out), 0);
      chk("rstmem_ready", 32'(ins_ready_out), 1);
      chk("rstmem_no_result", 32'(result_valid_out), 0);
      issue(rtype(1, 2, 14, 0, T_ADDU), 0);
      chk("rstmem_r1_cleared", alu_a_out, 0);
      chk("rstmem_r2_cleared", alu_b_out, 0);
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
